// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: decode control, instruction memory port, status outputs
interface fetch_unit_if;
  logic [31:0] i_PC;
  logic        i_STALL;
  logic        i_FLUSH;
  logic        o_IMEM_REQ;
  logic [31:0] o_IMEM_ADDR;
  logic        i_IMEM_ACK;
  logic [31:0] i_IMEM_RDATA;
  logic [31:0] o_INSTRUCTION;
  logic        o_EN;
  logic        o_FETCH_ERR;
  logic [1:0]  o_ERR_CAUSE;
  logic        o_BUSY;

  modport master (
    input  i_PC, i_STALL, i_FLUSH, i_IMEM_ACK, i_IMEM_RDATA,
    output o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION, o_EN, o_FETCH_ERR, o_ERR_CAUSE, o_BUSY
  );

  modport slave (
    output i_PC, i_STALL, i_FLUSH, i_IMEM_ACK, i_IMEM_RDATA,
    input  o_IMEM_REQ, o_IMEM_ADDR, o_INSTRUCTION, o_EN, o_FETCH_ERR, o_ERR_CAUSE, o_BUSY
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: req/ack memory read, hold word for decode, flush and error handling
module fetch_unit #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic        req;
  logic        en;
  logic        pc_misaligned;

  assign pc_misaligned = (bus.i_PC[1:0] != 2'b00);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_REQ;
      cnt_q   <= 16'd0;
      instr_q <= NOP;
      err_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    err_d   = err_q;
    cause_d = cause_q;
    req     = (state_q == S_REQ) && !pc_misaligned && !bus.i_FLUSH;
    en      = (state_q == S_VALID) && !bus.i_STALL && !bus.i_FLUSH;

    // Flush outranks everything, including a same-cycle ack or timeout expiry.
    if (bus.i_FLUSH) begin
      state_d = S_REQ;
      cnt_d   = 16'd0;
      err_d   = 1'b0;
      cause_d = 2'b00;
    end else begin
      case (state_q)
        S_REQ: begin
          if (pc_misaligned) begin
            state_d = S_ERR;
            cnt_d   = 16'd0;
            err_d   = 1'b1;
            cause_d = 2'b01;
          end else if (bus.i_IMEM_ACK) begin
            state_d = S_VALID;
            cnt_d   = 16'd0;
            instr_d = bus.i_IMEM_RDATA;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            state_d = S_ERR;
            cnt_d   = 16'd0;
            err_d   = 1'b1;
            cause_d = 2'b10;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_VALID: begin
          if (en) begin
            state_d = S_REQ;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  assign bus.o_IMEM_REQ    = req;
  assign bus.o_IMEM_ADDR   = {bus.i_PC[31:2], 2'b00};
  assign bus.o_INSTRUCTION = instr_q;
  assign bus.o_EN          = en;
  assign bus.o_FETCH_ERR   = err_q;
  assign bus.o_ERR_CAUSE   = cause_q;
  assign bus.o_BUSY        = (state_q == S_REQ);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural fetch model
module tb_fetch_unit;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int M_FETCH = 0;
  localparam int M_HOLD  = 1;
  localparam int M_HALT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(.TIMEOUT(TO), .NOP(NOP)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h00500093 : {a[15:0], 16'h0093};
  endfunction

  // Memory responder: acks after ack_delay request cycles, or on demand.
  int   ack_delay = 0;
  int   reqcnt    = 0;
  logic force_ack = 1'b0;

  always_comb begin
    bus.i_IMEM_ACK   = force_ack | (bus.o_IMEM_REQ && (reqcnt >= ack_delay));
    bus.i_IMEM_RDATA = force_ack ? 32'hDEADBEEF : mem_word(bus.o_IMEM_ADDR);
  end

  always @(posedge clk) begin
    if (bus.o_IMEM_REQ && !bus.i_IMEM_ACK) reqcnt <= reqcnt + 1;
    else                                   reqcnt <= 0;
  end

  // Behavioural model: what the fetch stage is doing and what it must show.
  int          m_mode;
  int          m_waited;
  logic [31:0] m_instr;
  logic        m_err;
  logic [1:0]  m_cause;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode   = M_FETCH;
      m_waited = 0;
      m_instr  = NOP;
      m_err    = 1'b0;
      m_cause  = 2'b00;
    end else if (bus.i_FLUSH) begin
      m_mode   = M_FETCH;
      m_waited = 0;
      m_err    = 1'b0;
      m_cause  = 2'b00;
    end else if (m_mode == M_FETCH) begin
      if (bus.i_PC % 4 != 0) begin
        m_mode  = M_HALT;
        m_err   = 1'b1;
        m_cause = 2'b01;
      end else if (bus.i_IMEM_ACK) begin
        m_instr  = bus.i_IMEM_RDATA;
        m_mode   = M_HOLD;
        m_waited = 0;
      end else begin
        m_waited = m_waited + 1;
        if (TO != 0 && m_waited >= TO) begin
          m_mode   = M_HALT;
          m_err    = 1'b1;
          m_cause  = 2'b10;
          m_waited = 0;
        end
      end
    end else if (m_mode == M_HOLD) begin
      if (!bus.i_STALL) m_mode = M_FETCH;
    end
  end

  logic chk_on = 1'b1;

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      logic exp_req;
      exp_req = (m_mode == M_FETCH) && (bus.i_PC % 4 == 0) && !bus.i_FLUSH;
      chk("req", {31'd0, bus.o_IMEM_REQ}, {31'd0, exp_req});
      if (exp_req) chk("addr", bus.o_IMEM_ADDR, bus.i_PC & 32'hFFFF_FFFC);
      chk("en", {31'd0, bus.o_EN},
          {31'd0, (m_mode == M_HOLD) && !bus.i_STALL && !bus.i_FLUSH});
      chk("instr", bus.o_INSTRUCTION, m_instr);
      chk("err", {31'd0, bus.o_FETCH_ERR}, {31'd0, m_err});
      chk("cause", {30'd0, bus.o_ERR_CAUSE}, {30'd0, m_cause});
      chk("busy", {31'd0, bus.o_BUSY}, {31'd0, m_mode == M_FETCH});
    end
  end

  // One cycle: snapshot outputs mid-cycle, then let decode advance its PC on o_EN.
  logic        s_req, s_en, s_err, s_busy;
  logic [31:0] s_addr, s_instr;
  logic [1:0]  s_cause;

  task automatic cycle();
    @(negedge clk);
    #1;
    s_req   = bus.o_IMEM_REQ;
    s_addr  = bus.o_IMEM_ADDR;
    s_en    = bus.o_EN;
    s_instr = bus.o_INSTRUCTION;
    s_err   = bus.o_FETCH_ERR;
    s_cause = bus.o_ERR_CAUSE;
    s_busy  = bus.o_BUSY;
    @(posedge clk);
    #2;
    if (s_en) bus.i_PC = bus.i_PC + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    int n_en;
    int en_at;
    int n_cyc;
    bus.i_PC    = 32'd0;
    bus.i_STALL = 1'b0;
    bus.i_FLUSH = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_instr", bus.o_INSTRUCTION, NOP);
    chk("rst_en", {31'd0, bus.o_EN}, 32'd0);
    chk("rst_err", {31'd0, bus.o_FETCH_ERR}, 32'd0);
    chk("rst_cause", {30'd0, bus.o_ERR_CAUSE}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_BUSY}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // zero-wait fetch from address 0
    cycle();
    chk("t1_req", {31'd0, s_req}, 32'd1);
    chk("t1_addr", s_addr, 32'd0);
    cycle();
    chk("t1_en", {31'd0, s_en}, 32'd1);
    chk("t1_instr", s_instr, 32'h00500093);
    cycle();
    chk("t1_req_next", {31'd0, s_req}, 32'd1);
    chk("t1_addr_next", s_addr, 32'd4);
    cycle();

    // three wait states at pc 8
    ack_delay = 3;
    n_req = 0; n_en = 0; en_at = 0;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (s_req) begin
        n_req++;
        chk("t2_addr_stable", s_addr, 32'd8);
      end
      if (s_en) begin
        n_en++;
        en_at = i;
      end
    end
    chk("t2_req_cycles", n_req, 32'd4);
    chk("t2_en_count", n_en, 32'd1);
    chk("t2_en_cycle", en_at, 32'd5);
    ack_delay = 0;

    // stall for 5 cycles while holding the word from pc 12
    cycle();
    bus.i_STALL = 1'b1;
    n_en = 0;
    repeat (5) begin
      cycle();
      if (s_en) n_en++;
      chk("t3_hold", s_instr, mem_word(32'd12));
    end
    chk("t3_en_stalled", n_en, 32'd0);
    bus.i_STALL = 1'b0;
    cycle();
    chk("t3_en_release", {31'd0, s_en}, 32'd1);

    // flush coincident with an ack of DEADBEEF
    ack_delay   = 1000;
    force_ack   = 1'b1;
    bus.i_FLUSH = 1'b1;
    bus.i_PC    = 32'h00000100;
    cycle();
    chk("t4_no_en", {31'd0, s_en}, 32'd0);
    force_ack   = 1'b0;
    bus.i_FLUSH = 1'b0;
    ack_delay   = 0;
    cycle();
    chk("t4_redirect_req", {31'd0, s_req}, 32'd1);
    chk("t4_redirect_addr", s_addr, 32'h00000100);
    chk("t4_kept_instr", s_instr, mem_word(32'd12));
    cycle();

    // misaligned pc
    bus.i_PC = 32'h00000006;
    cycle();
    chk("t5_no_req", {31'd0, s_req}, 32'd0);
    cycle();
    chk("t5_err", {31'd0, s_err}, 32'd1);
    chk("t5_cause", {30'd0, s_cause}, 32'd1);
    repeat (3) cycle();
    chk("t5_err_held", {31'd0, s_err}, 32'd1);
    chk("t5_req_held", {31'd0, s_req}, 32'd0);
    bus.i_FLUSH = 1'b1;
    bus.i_PC    = 32'd8;
    cycle();
    bus.i_FLUSH = 1'b0;
    cycle();
    chk("t5_err_clear", {31'd0, s_err}, 32'd0);
    chk("t5_cause_clear", {30'd0, s_cause}, 32'd0);
    chk("t5_req_after", {31'd0, s_req}, 32'd1);
    cycle();

    // timeout with no ack at pc 12
    ack_delay = 1000;
    n_req = 0;
    n_cyc = 0;
    while (n_cyc < 40) begin
      cycle();
      n_cyc++;
      if (s_req) n_req++;
      if (!s_busy) break;
    end
    chk("t6_reached_err", {31'd0, s_busy}, 32'd0);
    chk("t6_req_cycles", n_req, 32'd16);
    chk("t6_cause", {30'd0, s_cause}, 32'd2);
    chk("t6_err", {31'd0, s_err}, 32'd1);

    // asynchronous reset in the middle of a wait
    bus.i_FLUSH = 1'b1;
    cycle();
    bus.i_FLUSH = 1'b0;
    repeat (5) cycle();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_arst_instr", bus.o_INSTRUCTION, NOP);
    chk("t6_arst_err", {31'd0, bus.o_FETCH_ERR}, 32'd0);
    chk("t6_arst_cause", {30'd0, bus.o_ERR_CAUSE}, 32'd0);
    chk("t6_arst_en", {31'd0, bus.o_EN}, 32'd0);
    chk("t6_arst_busy", {31'd0, bus.o_BUSY}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    ack_delay = 0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
